// File: rtl/morph_pass_sched.sv
// morph_pass_sched: pass scheduler for the binary-morphology datapath.
// Generates the raster scan and frame-buffer addresses for each pass and
// selects erode or dilate for that pass. Between passes it flushes the
// datapath latency and swaps the ping-pong read bank.
// Optional feature: define MORPH_SCHED_ABORT_EN to add the i_abort input.
//
// Host handshake: i_start is sampled only in IDLE. o_busy is high from the
// first SCAN cycle through the last FLUSH cycle. o_done pulses for exactly
// one cycle when the sequence ends. There is no backpressure: the datapath
// must accept one pixel per cycle while o_pix_valid is high.
module morph_pass_sched #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIPE_LAT = 2,
  parameter int ADDR_W   = 19
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [3:0]        i_n_erode,
  input  logic [3:0]        i_n_dilate,
`ifdef MORPH_SCHED_ABORT_EN
  input  logic              i_abort,
`endif
  output logic [10:0]       o_hcount,
  output logic [10:0]       o_vcount,
  output logic              o_pix_valid,
  output logic              o_op_sel,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_bank,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_wr_en,
  output logic [4:0]        o_pass_idx,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_state
);

  localparam int FC_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              r_mode;
  logic [3:0]        r_n_erode;
  logic [3:0]        r_n_dilate;
  logic [4:0]        r_total;
  logic [4:0]        r_pass_idx;
  logic              r_rd_bank;
  logic              r_aborted;
  logic [10:0]       r_hcount;
  logic [10:0]       r_vcount;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [FC_W-1:0]   r_flush_cnt;
  logic [PIPE_LAT-1:0] r_wr_en_dly;
  logic [ADDR_W-1:0] r_wr_addr_dly [PIPE_LAT];

  logic              w_abort;
  logic [4:0]        w_total_in;
  logic              w_scan_end;
  logic              w_flush_end;
  logic              w_last_pass;
  logic              w_pix_valid;
  logic              w_busy;
  logic              w_done;
  logic              w_op_sel;

`ifdef MORPH_SCHED_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_total_in  = {1'b0, i_n_erode} + {1'b0, i_n_dilate};
  assign w_scan_end  = (r_hcount == 11'(H_ACTIVE - 1)) && (r_vcount == 11'(V_ACTIVE - 1));
  assign w_flush_end = (r_flush_cnt == FC_W'(PIPE_LAT - 1));
  assign w_last_pass = (r_pass_idx == (r_total - 5'd1));

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode and per-state strobes
  always_comb begin
    w_next_state = r_state;
    w_pix_valid  = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next_state = (w_total_in == 5'd0) ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: begin
        w_pix_valid = ~w_abort;
        w_busy      = 1'b1;
        if (w_abort || w_scan_end) w_next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_busy = 1'b1;
        if (w_flush_end)
          w_next_state = (w_last_pass || r_aborted || w_abort) ? ST_DONE : ST_SCAN;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Sequence registers: latched config, scan counters, pass and bank tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode      <= 1'b0;
      r_n_erode   <= '0;
      r_n_dilate  <= '0;
      r_total     <= '0;
      r_pass_idx  <= '0;
      r_rd_bank   <= 1'b0;
      r_aborted   <= 1'b0;
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_rd_addr   <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mode     <= i_mode;
            r_n_erode  <= i_n_erode;
            r_n_dilate <= i_n_dilate;
            r_total    <= w_total_in;
            r_pass_idx <= '0;
            r_rd_bank  <= 1'b0;
            r_aborted  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (w_next_state == ST_FLUSH) begin
            // Counters park at 0 for the flush and the next pass
            r_hcount    <= '0;
            r_vcount    <= '0;
            r_rd_addr   <= '0;
            r_flush_cnt <= '0;
            r_aborted   <= w_abort;
          end else if (r_hcount == 11'(H_ACTIVE - 1)) begin
            r_hcount  <= '0;
            r_vcount  <= r_vcount + 11'd1;
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end else begin
            r_hcount  <= r_hcount + 11'd1;
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
        ST_FLUSH: begin
          r_flush_cnt <= r_flush_cnt + FC_W'(1);
          if (w_abort) r_aborted <= 1'b1;
          // An aborted run never toggles here, so rd_bank keeps the last complete image
          if (w_next_state == ST_SCAN) begin
            r_pass_idx <= r_pass_idx + 5'd1;
            r_rd_bank  <= ~r_rd_bank;
          end
        end
        default: ;
      endcase
    end
  end

  // Write-side delay line matching the datapath latency
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_en_dly <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_wr_addr_dly[i] <= '0;
    end else begin
      r_wr_en_dly[0]   <= w_pix_valid;
      r_wr_addr_dly[0] <= r_rd_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_wr_en_dly[i]   <= r_wr_en_dly[i-1];
        r_wr_addr_dly[i] <= r_wr_addr_dly[i-1];
      end
    end
  end

  // Opening erodes first, closing dilates first; forced 0 outside a pass
  always_comb begin
    w_op_sel = 1'b0;
    if (w_busy) begin
      if (r_mode == 1'b0) w_op_sel = ~(r_pass_idx < {1'b0, r_n_erode});
      else                w_op_sel =  (r_pass_idx < {1'b0, r_n_dilate});
    end
  end

  assign o_hcount    = r_hcount;
  assign o_vcount    = r_vcount;
  assign o_pix_valid = w_pix_valid;
  assign o_op_sel    = w_op_sel;
  assign o_rd_addr   = r_rd_addr;
  assign o_rd_bank   = r_rd_bank;
  assign o_wr_addr   = r_wr_addr_dly[PIPE_LAT-1];
  assign o_wr_en     = r_wr_en_dly[PIPE_LAT-1];
  assign o_pass_idx  = r_pass_idx;
  assign o_busy      = w_busy;
  assign o_done      = w_done;
  assign o_state     = r_state;

endmodule

// File: tb/tb_morph_pass_sched.sv
// tb_morph_pass_sched: randomized bench for morph_pass_sched against a
// cycle-indexed reference model (small 4x3 frame, 2-cycle datapath).
module tb_morph_pass_sched;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int P   = 2;
  localparam int AW  = 4;
  localparam int PIX = H * V;
  localparam int PER = PIX + P;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [3:0]    n_erode = '0;
  logic [3:0]    n_dilate = '0;
`ifdef MORPH_SCHED_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic [10:0]   hcount, vcount;
  logic          pix_valid, op_sel, rd_bank, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [4:0]    pass_idx;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;
  logic [AW-1:0] exp_q[$];

  morph_pass_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .PIPE_LAT(P), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_n_erode(n_erode), .i_n_dilate(n_dilate),
`ifdef MORPH_SCHED_ABORT_EN
    .i_abort(abort),
`endif
    .o_hcount(hcount), .o_vcount(vcount), .o_pix_valid(pix_valid), .o_op_sel(op_sel),
    .o_rd_addr(rd_addr), .o_rd_bank(rd_bank), .o_wr_addr(wr_addr), .o_wr_en(wr_en),
    .o_pass_idx(pass_idx), .o_busy(busy), .o_done(done), .o_state(state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input bit full);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check({tag, "_hcount"},    32'(hcount),    32'd0);
    check({tag, "_vcount"},    32'(vcount),    32'd0);
    check({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, "_op_sel"},    32'(op_sel),    32'd0);
    check({tag, "_state"},     32'(state),     32'd0);
    if (full) begin
      check({tag, "_pass_idx"}, 32'(pass_idx), 32'd0);
      check({tag, "_rd_bank"},  32'(rd_bank),  32'd0);
    end
  endtask

  // Drive one sequence and compare every cycle until done; junk=1 toggles
  // start and the config inputs while the sequence is running.
  task automatic run_seq(input logic m, input logic [3:0] ne, input logic [3:0] nd, input bit junk);
    int total, last, p, o;
    logic e_pix, e_wr;
    total = int'(ne) + int'(nd);
    last  = (total == 0) ? 1 : total * PER + 1;
    for (int pp = 0; pp < total; pp++)
      for (int a = 0; a < PIX; a++) exp_q.push_back(AW'(a));
    mode = m; n_erode = ne; n_dilate = nd; start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      tick();
      if (c == last) begin
        check("done_pulse",  32'(done),      32'd1);
        check("done_busy",   32'(busy),      32'd0);
        check("done_pix",    32'(pix_valid), 32'd0);
        check("done_wr_en",  32'(wr_en),     32'd0);
        start = 1'b0;
      end else begin
        p = (c - 1) / PER;
        o = (c - 1) % PER;
        e_pix = (o < PIX);
        e_wr  = (o >= P) && (o < PIX + P);
        check("busy",      32'(busy),      32'd1);
        check("done",      32'(done),      32'd0);
        check("pix_valid", 32'(pix_valid), 32'(e_pix));
        check("hcount",    32'(hcount),    e_pix ? 32'(o % H) : 32'd0);
        check("vcount",    32'(vcount),    e_pix ? 32'(o / H) : 32'd0);
        check("rd_addr",   32'(rd_addr),   e_pix ? 32'(o) : 32'd0);
        check("pass_idx",  32'(pass_idx),  32'(p));
        check("rd_bank",   32'(rd_bank),   32'(p % 2));
        check("op_sel",    32'(op_sel),    (m == 1'b0) ? 32'(p >= int'(ne)) : 32'(p < int'(nd)));
        check("wr_en",     32'(wr_en),     32'(e_wr));
        if (wr_en) begin
          if (exp_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
          else                   check("wr_addr", 32'(wr_addr), 32'(exp_q.pop_front()));
        end
        if (junk) begin
          start    = 1'($urandom_range(0, 1));
          mode     = 1'($urandom_range(0, 1));
          n_erode  = 4'($urandom_range(0, 15));
          n_dilate = 4'($urandom_range(0, 15));
        end else begin
          start = 1'b0;
        end
      end
    end
    check("wr_q_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    check("after_done", 32'(done), 32'd0);
    check("after_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset, then idle quietly
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_quiet("idle", 1'b1);
    end

    run_seq(1'b0, 4'd1, 4'd0, 1'b0);
    run_seq(1'b0, 4'd1, 4'd2, 1'b0);
    run_seq(1'b1, 4'd2, 4'd1, 1'b1);
    run_seq(1'b0, 4'd0, 4'd0, 1'b0);
    for (int k = 0; k < 6; k++)
      run_seq(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'b1);

    // Reset in the middle of a pass drops everything, including pending writes
    mode = 1'b0; n_erode = 4'd1; n_dilate = 4'd0; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = 1'b0;
    end
    check("mid_pix_valid", 32'(pix_valid), 32'd1);
    check("mid_wr_en",     32'(wr_en),     32'd1);
    rst = 1'b1;
    tick();
    check_quiet("rst_mid", 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_quiet("post_rst", 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
